// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data memory between
// the MEM stage (port 0) and the debug/loader port (port 1).
module dmem_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              stall0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic              grant_id;
  logic              winner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rdata0, rdata1;

  // On a tie the port that did not win last time is served.
  always_comb begin
    winner = 1'b0;
    if (req0_i && req1_i) winner = ~last_grant;
    else                  winner = req1_i;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0_i || req1_i) state_next = ACCESS;
      ACCESS:  if (count == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      count      <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            grant_id  <= winner;
            lat_we    <= winner ? we1_i    : we0_i;
            lat_addr  <= winner ? addr1_i  : addr0_i;
            lat_wdata <= winner ? wdata1_i : wdata0_i;
            count     <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (count != '0) count <= count - 1'b1;
          else if (!lat_we) begin
            if (grant_id) rdata1 <= mem_rdata_i;
            else          rdata0 <= mem_rdata_i;
          end
        end
        RESP:    last_grant <= grant_id;
        default: ;
      endcase
    end
  end

  // Memory strobes derive from state and latched fields only, so reset
  // drops them immediately and the req inputs cannot glitch them.
  assign mem_addr_o  = (state == ACCESS) ? lat_addr  : '0;
  assign mem_wdata_o = (state == ACCESS) ? lat_wdata : '0;
  assign mem_wr_o    = (state == ACCESS) &  lat_we;
  assign mem_rd_o    = (state == ACCESS) & ~lat_we;

  assign ack0_o   = (state == RESP) & ~grant_id;
  assign ack1_o   = (state == RESP) &  grant_id;
  assign stall0_o = req0_i & ~ack0_o;
  assign busy_o   = (state != IDLE);
  assign rdata0_o = rdata0;
  assign rdata1_o = rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at LATENCY=1 with a small
// memory model, and one at LATENCY=4 for the multi-cycle strobe timing.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, stall0, busy, mem_wr, mem_rd;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic        q_req0;
  logic [31:0] q_addr0;
  logic        q_ack0, q_ack1, q_stall0, q_busy, q_mem_wr, q_mem_rd;
  logic [31:0] q_rdata0, q_rdata1, q_mem_addr, q_mem_wdata, q_mem_rdata;

  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ack0_o(ack0), .rdata0_o(rdata0), .stall0_o(stall0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ack1_o(ack1), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wr_o(mem_wr),
    .mem_rd_o(mem_rd), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_arbiter #(.LATENCY(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk_i(clk), .rst_i(rst4),
    .req0_i(q_req0), .we0_i(1'b0), .addr0_i(q_addr0), .wdata0_i(32'h0),
    .ack0_o(q_ack0), .rdata0_o(q_rdata0), .stall0_o(q_stall0),
    .req1_i(1'b0), .we1_i(1'b0), .addr1_i(32'h0), .wdata1_i(32'h0),
    .ack1_o(q_ack1), .rdata1_o(q_rdata1),
    .mem_addr_o(q_mem_addr), .mem_wdata_o(q_mem_wdata), .mem_wr_o(q_mem_wr),
    .mem_rd_o(q_mem_rd), .mem_rdata_i(q_mem_rdata), .busy_o(q_busy)
  );

  always @(posedge clk) begin
    if (mem_wr)     mem[mem_addr[3:0]] <= mem_wdata;
    else if (pl_en) mem[pl_addr]       <= pl_data;
  end
  assign mem_rdata   = mem[mem_addr[3:0]];
  assign q_mem_rdata = {16'hCAFE, q_mem_addr[15:0]};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    q_req0 = 0; q_addr0 = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    rst = 1; rst4 = 1;
    #3;
    checks++; if ({ack0, ack1, busy, mem_wr, mem_rd, stall0} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b want 000000", {ack0, ack1, busy, mem_wr, mem_rd, stall0}); end
    checks++; if ({rdata0, rdata1, mem_addr} !== 96'h0) begin
      errors++; $display("[TB] FAIL reset_data got %h %h %h want 0", rdata0, rdata1, mem_addr); end
    checks++; if ({q_busy, q_mem_rd, q_ack0} !== 3'b0) begin
      errors++; $display("[TB] FAIL reset_lat4 got %b want 000", {q_busy, q_mem_rd, q_ack0}); end
    tick; tick;
    rst = 0; rst4 = 0;
    pl_en = 1; pl_addr = 4; pl_data = 32'hDEADBEEF;
    tick;
    pl_en = 0;
    tick;
  endtask

  task automatic test_single_read;
    req0 = 1; we0 = 0; addr0 = 4;
    #1;
    checks++; if (stall0 !== 1'b1) begin errors++; $display("[TB] FAIL t1_stall_E got %b want 1", stall0); end
    tick;
    checks++; if ({mem_rd, mem_wr, ack0, stall0, busy} !== 5'b10011) begin
      errors++; $display("[TB] FAIL t1_access got %b want 10011", {mem_rd, mem_wr, ack0, stall0, busy}); end
    checks++; if (mem_addr !== 32'd4) begin errors++; $display("[TB] FAIL t1_addr got %h want 4", mem_addr); end
    tick;
    checks++; if ({mem_rd, ack0, ack1, stall0} !== 4'b0100) begin
      errors++; $display("[TB] FAIL t1_resp got %b want 0100", {mem_rd, ack0, ack1, stall0}); end
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL t1_rdata0 got %h want deadbeef", rdata0); end
    req0 = 0;
    tick;
    checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("[TB] FAIL t1_idle got %b want 00", {busy, ack0}); end
  endtask

  task automatic test_write_then_read;
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 32'h12345678;
    tick;
    checks++; if ({mem_wr, mem_rd} !== 2'b10) begin errors++; $display("[TB] FAIL t2_strobe got %b want 10", {mem_wr, mem_rd}); end
    checks++; if (mem_addr !== 32'd3 || mem_wdata !== 32'h12345678) begin
      errors++; $display("[TB] FAIL t2_bus got %h/%h want 3/12345678", mem_addr, mem_wdata); end
    tick;
    checks++; if ({mem_wr, ack1, ack0} !== 3'b010) begin errors++; $display("[TB] FAIL t2_ack1 got %b want 010", {mem_wr, ack1, ack0}); end
    req1 = 0; we1 = 0;
    tick;
    req0 = 1; we0 = 0; addr0 = 3;
    tick; tick;
    checks++; if (ack0 !== 1'b1 || rdata0 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL t2_read got ack %b data %h want 1/12345678", ack0, rdata0); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL t2_rdata1 got %h want 0", rdata1); end
    req0 = 0;
    tick;
  endtask

  task automatic test_round_robin;
    int n = 0, n0 = 0, n1 = 0, both = 0;
    rst = 1; #2; tick; rst = 0;
    req0 = 1; we0 = 0; addr0 = 4;
    req1 = 1; we1 = 0; addr1 = 3;
    for (int c = 0; c < 60 && n < 8; c++) begin
      tick;
      if (ack0 && ack1) both++;
      if (ack0 || ack1) begin
        checks++; if (ack1 !== n[0]) begin
          errors++; $display("[TB] FAIL rr_order%0d got port %b want %b", n, ack1, n[0]); end
        if (ack0) n0++; else n1++;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL rr_timeout got %0d acks want 8", n); end
    checks++; if (both !== 0) begin errors++; $display("[TB] FAIL rr_both got %0d want 0", both); end
    checks++; if (n0 !== 4 || n1 !== 4) begin errors++; $display("[TB] FAIL rr_counts got %0d/%0d want 4/4", n0, n1); end
    checks++; if (rdata0 !== 32'hDEADBEEF || rdata1 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL rr_rdata got %h/%h want deadbeef/12345678", rdata0, rdata1); end
    tick; tick;
  endtask

  task automatic test_latency4;
    q_req0 = 1; q_addr0 = 7;
    tick;
    for (int c = 1; c <= 4; c++) begin
      checks++; if ({q_mem_rd, q_mem_wr, q_ack0, q_busy} !== 4'b1001) begin
        errors++; $display("[TB] FAIL lat4_access%0d got %b want 1001", c, {q_mem_rd, q_mem_wr, q_ack0, q_busy}); end
      tick;
    end
    checks++; if ({q_mem_rd, q_ack0, q_busy} !== 3'b011) begin
      errors++; $display("[TB] FAIL lat4_resp got %b want 011", {q_mem_rd, q_ack0, q_busy}); end
    checks++; if (q_rdata0 !== 32'hCAFE0007) begin errors++; $display("[TB] FAIL lat4_rdata got %h want cafe0007", q_rdata0); end
    q_req0 = 0;
    tick;
    checks++; if (q_busy !== 1'b0) begin errors++; $display("[TB] FAIL lat4_idle got %b want 0", q_busy); end
  endtask

  task automatic test_reset_mid_access;
    req1 = 1; we1 = 1; addr1 = 9; wdata1 = 32'h55;
    tick;
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL t5_pre got %b want 1", mem_wr); end
    #2 rst = 1;
    #1;
    checks++; if ({mem_wr, busy, ack1} !== 3'b000) begin
      errors++; $display("[TB] FAIL t5_async got %b want 000", {mem_wr, busy, ack1}); end
    req1 = 0; we1 = 0;
    tick; rst = 0;
    tick;
    checks++; if ({busy, ack1, rdata1 == 32'h0} !== 3'b001) begin
      errors++; $display("[TB] FAIL t5_after got %b want 001", {busy, ack1, rdata1 == 32'h0}); end
    req1 = 1; addr1 = 3;
    tick;
    checks++; if ({mem_rd, busy} !== 2'b11) begin errors++; $display("[TB] FAIL t5_fresh_acc got %b want 11", {mem_rd, busy}); end
    tick;
    checks++; if (ack1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      errors++; $display("[TB] FAIL t5_fresh_ack got %b/%h want 1/12345678", ack1, rdata1); end
    req1 = 0;
    tick;
  endtask

  task automatic test_drop_req;
    int acks = 0;
    req0 = 1; we0 = 0; addr0 = 4;
    tick;
    req0 = 0;
    #1;
    checks++; if ({mem_rd, stall0} !== 2'b10) begin errors++; $display("[TB] FAIL t6_access got %b want 10", {mem_rd, stall0}); end
    for (int c = 0; c < 4; c++) begin
      tick;
      if (ack0) acks++;
    end
    checks++; if (acks !== 1) begin errors++; $display("[TB] FAIL t6_acks got %0d want 1", acks); end
    checks++; if ({busy, mem_rd, rdata0 == 32'hDEADBEEF} !== 3'b001) begin
      errors++; $display("[TB] FAIL t6_idle got %b want 001", {busy, mem_rd, rdata0 == 32'hDEADBEEF}); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_then_read;
    test_round_robin;
    test_latency4;
    test_reset_mid_access;
    test_drop_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
